// File: rtl/ccd_sharp_pkg.sv
// ccd_sharp_pkg: region codes, sequencer state encodings and frame-size helper
package ccd_sharp_pkg;
   localparam logic [1:0] DUMMY = 2'd0;
   localparam logic [1:0] BLACK = 2'd1;
   localparam logic [1:0] IMAGE = 2'd2;
   localparam logic [1:0] PAD   = 2'd3;
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_XSG     = 3'd1;
   localparam logic [2:0] ST_XSG_GAP = 3'd2;
   localparam logic [2:0] ST_XV      = 3'd3;
   localparam logic [2:0] ST_XV_GAP  = 3'd4;
   localparam logic [2:0] ST_HREAD   = 3'd5;
   localparam logic [2:0] ST_FEND    = 3'd6;
   function automatic int v_total(input int a, input int b, input int c, input int d, input int e);
      return a + b + c + d + e;
   endfunction
endpackage

// File: rtl/ccd_sharp_region_decode.sv
// ccd_sharp_region_decode: maps an index onto dummy/black/image/black/dummy/pad regions
module ccd_sharp_region_decode
   import ccd_sharp_pkg::*;
(
   input  logic [15:0] i_idx,
   input  logic [15:0] i_len0,
   input  logic [15:0] i_len1,
   input  logic [15:0] i_len2,
   input  logic [15:0] i_len3,
   input  logic [15:0] i_len4,
   output logic [1:0]  ov_type
);
   logic [17:0] w_idx, w_e0, w_e1, w_e2, w_e3, w_e4;
   // Running region end positions, then first region whose end lies past the index
   always_comb begin
      w_idx   = {2'b0, i_idx};
      w_e0    = {2'b0, i_len0};
      w_e1    = w_e0 + {2'b0, i_len1};
      w_e2    = w_e1 + {2'b0, i_len2};
      w_e3    = w_e2 + {2'b0, i_len3};
      w_e4    = w_e3 + {2'b0, i_len4};
      ov_type = (w_idx < w_e0) ? DUMMY :
                (w_idx < w_e1) ? BLACK :
                (w_idx < w_e2) ? IMAGE :
                (w_idx < w_e3) ? BLACK :
                (w_idx < w_e4) ? DUMMY : PAD;
   end
endmodule

// File: rtl/ccd_sharp_timing_ctrl.sv
// ccd_sharp_timing_ctrl: Sharp CCD frame/line sequencer with XSG/XV pulses, readout pacing and region tagging
module ccd_sharp_timing_ctrl
   import ccd_sharp_pkg::*;
#(
   parameter int ALLPIX_PER_LINE = 1376,
   parameter int DUMMY_HFRONT    = 4,
   parameter int BLACK_HFRONT    = 12,
   parameter int IMAGE_WIDTH     = 1320,
   parameter int BLACK_HREAR     = 40,
   parameter int DUMMY_HREAR     = 0,
   parameter int DUMMY_VFRONT    = 2,
   parameter int BLACK_VFRONT    = 8,
   parameter int IMAGE_HEIGHT    = 1032,
   parameter int BLACK_VREAR     = 2,
   parameter int DUMMY_VREAR     = 0,
   parameter int XSG_WIDTH       = 64,
   parameter int XSG_GAP         = 32,
   parameter int XV_WIDTH        = 16,
   parameter int XV_GAP          = 8
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_acq_en,
   output logic        o_xsg,
   output logic        o_xv,
   output logic        o_hread,
   output logic [15:0] ov_hcnt,
   output logic [15:0] ov_vcnt,
   output logic [1:0]  ov_pix_type,
   output logic [1:0]  ov_line_type,
   output logic        o_fval,
   output logic        o_lval,
   output logic        o_frame_done,
   output logic        o_busy
);
   localparam int V_TOTAL = v_total(DUMMY_VFRONT, BLACK_VFRONT, IMAGE_HEIGHT, BLACK_VREAR, DUMMY_VREAR);
   localparam int H_SUM   = DUMMY_HFRONT + BLACK_HFRONT + IMAGE_WIDTH + BLACK_HREAR + DUMMY_HREAR;

   if (XSG_WIDTH < 1 || XSG_GAP < 1 || XV_WIDTH < 1 || XV_GAP < 1 || IMAGE_WIDTH < 1 ||
       IMAGE_HEIGHT < 1 || H_SUM > ALLPIX_PER_LINE) begin : g_bad_params
      $error("ccd_sharp_timing_ctrl: illegal timing/region parameters");
   end

   logic [2:0]  r_state, w_next;
   logic [15:0] r_cnt, r_vcnt, w_len_m1;
   logic        r_seen, w_last, w_hread;
   logic [1:0]  w_pix, w_line;

   // Length of the current phase minus one; single-clock states use zero
   always_comb begin
      w_len_m1 = (r_state == ST_XSG)     ? 16'(XSG_WIDTH - 1) :
                 (r_state == ST_XSG_GAP) ? 16'(XSG_GAP - 1) :
                 (r_state == ST_XV)      ? 16'(XV_WIDTH - 1) :
                 (r_state == ST_XV_GAP)  ? 16'(XV_GAP - 1) :
                 (r_state == ST_HREAD)   ? 16'(ALLPIX_PER_LINE - 1) : 16'd0;
      w_last   = r_cnt == w_len_m1;
   end

   // Next-state decode; enable is only looked at in IDLE so frames always complete
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    w_next = i_acq_en ? ST_XSG : ST_IDLE;
         ST_XSG:     w_next = w_last ? ST_XSG_GAP : ST_XSG;
         ST_XSG_GAP: w_next = w_last ? ST_XV : ST_XSG_GAP;
         ST_XV:      w_next = w_last ? ST_XV_GAP : ST_XV;
         ST_XV_GAP:  w_next = w_last ? ST_HREAD : ST_XV_GAP;
         ST_HREAD:   w_next = !w_last ? ST_HREAD : (r_vcnt < 16'(V_TOTAL - 1)) ? ST_XV : ST_FEND;
         default:    w_next = ST_IDLE;
      endcase
   end

   // State, phase/pixel counter, line counter and "image data seen this frame" flag
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_vcnt  <= '0;
         r_seen  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_last ? 16'd0 : r_cnt + 16'd1;
         if (r_state == ST_IDLE && i_acq_en)
            r_vcnt <= '0;
         else if (r_state == ST_HREAD && w_next == ST_XV)
            r_vcnt <= r_vcnt + 16'd1;
         r_seen  <= (r_state == ST_IDLE) ? 1'b0 : (r_seen | o_lval);
      end
   end

   ccd_sharp_region_decode u_hdec (
      .i_idx(r_cnt), .i_len0(16'(DUMMY_HFRONT)), .i_len1(16'(BLACK_HFRONT)), .i_len2(16'(IMAGE_WIDTH)),
      .i_len3(16'(BLACK_HREAR)), .i_len4(16'(DUMMY_HREAR)), .ov_type(w_pix)
   );
   ccd_sharp_region_decode u_vdec (
      .i_idx(r_vcnt), .i_len0(16'(DUMMY_VFRONT)), .i_len1(16'(BLACK_VFRONT)), .i_len2(16'(IMAGE_HEIGHT)),
      .i_len3(16'(BLACK_VREAR)), .i_len4(16'(DUMMY_VREAR)), .ov_type(w_line)
   );

   assign w_hread      = r_state == ST_HREAD;
   assign o_xsg        = r_state == ST_XSG;
   assign o_xv         = r_state == ST_XV;
   assign o_hread      = w_hread;
   assign ov_hcnt      = w_hread ? r_cnt : 16'd0;
   assign ov_vcnt      = r_vcnt;
   assign ov_pix_type  = w_hread ? w_pix : DUMMY;
   assign ov_line_type = o_busy ? w_line : DUMMY;
   assign o_lval       = w_hread && w_line == IMAGE && w_pix == IMAGE;
   assign o_fval       = w_hread && w_line == IMAGE && (r_seen || o_lval);
   assign o_frame_done = r_state == ST_FEND;
   assign o_busy       = r_state != ST_IDLE;
endmodule

// File: tb/tb_ccd_sharp_timing_ctrl.sv
// tb_ccd_sharp_timing_ctrl: directed checks of frame/line timing, regions, enable drop and mid-frame reset
module tb_ccd_sharp_timing_ctrl;
   logic        clk = 1'b0, reset_n = 1'b0, en = 1'b0, en2 = 1'b0;
   logic        o_xsg, o_xv, o_hread, o_fval, o_lval, o_frame_done, o_busy;
   logic [15:0] ov_hcnt, ov_vcnt;
   logic [1:0]  ov_pix_type, ov_line_type;
   logic        b_xsg, b_xv, b_hread, b_fval, b_lval, b_frame_done, b_busy;
   logic [15:0] b_hcnt, b_vcnt;
   logic [1:0]  b_pix_type, b_line_type;
   logic [42:0] outs, outs2;
   int n_vec = 0, n_err = 0;
   int cyc, n_xsg, n_xv_rise, n_xv, n_hr, n_lval, n_burst, n_fval, bad_w, bad_map, exp_v;
   int rx, rv, rh;
   logic p_xsg, p_xv, p_hr, p_lval;
   logic [15:0] p_h;
   int xsg_q[$], fd_q[$];

   always #5 clk = ~clk;

   ccd_sharp_timing_ctrl #(
      .ALLPIX_PER_LINE(20), .DUMMY_HFRONT(1), .BLACK_HFRONT(2), .IMAGE_WIDTH(10), .BLACK_HREAR(3), .DUMMY_HREAR(0),
      .DUMMY_VFRONT(1), .BLACK_VFRONT(1), .IMAGE_HEIGHT(4), .BLACK_VREAR(1), .DUMMY_VREAR(0),
      .XSG_WIDTH(4), .XSG_GAP(2), .XV_WIDTH(2), .XV_GAP(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .i_acq_en(en), .o_xsg(o_xsg), .o_xv(o_xv), .o_hread(o_hread),
      .ov_hcnt(ov_hcnt), .ov_vcnt(ov_vcnt), .ov_pix_type(ov_pix_type), .ov_line_type(ov_line_type),
      .o_fval(o_fval), .o_lval(o_lval), .o_frame_done(o_frame_done), .o_busy(o_busy)
   );

   ccd_sharp_timing_ctrl #(
      .ALLPIX_PER_LINE(9), .DUMMY_HFRONT(0), .BLACK_HFRONT(1), .IMAGE_WIDTH(5), .BLACK_HREAR(1), .DUMMY_HREAR(1),
      .DUMMY_VFRONT(0), .BLACK_VFRONT(2), .IMAGE_HEIGHT(3), .BLACK_VREAR(0), .DUMMY_VREAR(1),
      .XSG_WIDTH(1), .XSG_GAP(1), .XV_WIDTH(1), .XV_GAP(1)
   ) dut2 (
      .clk(clk), .reset_n(reset_n), .i_acq_en(en2), .o_xsg(b_xsg), .o_xv(b_xv), .o_hread(b_hread),
      .ov_hcnt(b_hcnt), .ov_vcnt(b_vcnt), .ov_pix_type(b_pix_type), .ov_line_type(b_line_type),
      .o_fval(b_fval), .o_lval(b_lval), .o_frame_done(b_frame_done), .o_busy(b_busy)
   );

   assign outs  = {o_xsg, o_xv, o_hread, ov_hcnt, ov_vcnt, ov_pix_type, ov_line_type, o_fval, o_lval, o_frame_done, o_busy};
   assign outs2 = {b_xsg, b_xv, b_hread, b_hcnt, b_vcnt, b_pix_type, b_line_type, b_fval, b_lval, b_frame_done, b_busy};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Hand-written region maps for the small parameter set
   function automatic logic [1:0] hp(input logic [15:0] h);
      return (h == 0) ? 2'd0 : (h <= 2) ? 2'd1 : (h <= 12) ? 2'd2 : (h <= 15) ? 2'd1 : 2'd3;
   endfunction
   function automatic logic [1:0] vl(input logic [15:0] v);
      return (v == 0) ? 2'd0 : (v == 1) ? 2'd1 : (v <= 5) ? 2'd2 : 2'd1;
   endfunction

   task automatic clr();
      cyc = 0; n_xsg = 0; n_xv_rise = 0; n_xv = 0; n_hr = 0; n_lval = 0; n_burst = 0; n_fval = 0;
      bad_w = 0; bad_map = 0; exp_v = 0; rx = 0; rv = 0; rh = 0;
      p_xsg = o_xsg; p_xv = o_xv; p_hr = o_hread; p_lval = o_lval; p_h = ov_hcnt;
      xsg_q.delete(); fd_q.delete();
   endtask

   task automatic watch(input int n, input bit drop_v3);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         cyc++;
         if (o_xsg && !p_xsg) begin xsg_q.push_back(cyc); exp_v = 0; end
         if (o_xv && !p_xv) begin
            n_xv_rise++;
            if (ov_vcnt != 16'(exp_v)) bad_map++;
            exp_v++;
         end
         if (o_lval && !p_lval) n_burst++;
         if (o_frame_done) fd_q.push_back(cyc);
         n_xsg += int'(o_xsg); n_xv += int'(o_xv); n_hr += int'(o_hread); n_lval += int'(o_lval); n_fval += int'(o_fval);
         if (o_xsg) rx++; else begin if (p_xsg && rx != 4) bad_w++; rx = 0; end
         if (o_xv) rv++; else begin if (p_xv && rv != 2) bad_w++; rv = 0; end
         if (o_hread) rh++; else begin if (p_hr && rh != 20) bad_w++; rh = 0; end
         if (o_hread) begin
            if (ov_hcnt != (p_hr ? p_h + 16'd1 : 16'd0)) bad_map++;
            if (ov_pix_type != hp(ov_hcnt)) bad_map++;
         end else if (ov_hcnt != 0) bad_map++;
         if (o_busy && ov_line_type != vl(ov_vcnt)) bad_map++;
         if (o_lval != (o_hread && ov_hcnt >= 3 && ov_hcnt <= 12 && ov_vcnt >= 2 && ov_vcnt <= 5)) bad_map++;
         if (o_fval && !(o_hread && ov_vcnt >= 2 && ov_vcnt <= 5)) bad_map++;
         if (o_xsg && ov_vcnt != 0) bad_map++;
         if (drop_v3 && en && ov_vcnt == 3) en = 1'b0;
         p_xsg = o_xsg; p_xv = o_xv; p_hr = o_hread; p_lval = o_lval; p_h = ov_hcnt;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int found, c2, x2, xr2, hr2, lv2, lb2, fd2, fd2_first, pad2, fv2;
      logic pxv2, plv2;
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_outs", outs, 0);
      chk("rst_outs2", outs2, 0);
      // three back-to-back frames with enable held
      reset_n = 1'b1; en = 1'b1;
      clr();
      watch(3 * 169, 1'b0);
      chk("f3_xsg_rises", xsg_q.size(), 3);
      chk("f3_xsg_first", xsg_q[0], 1);
      chk("f3_xsg_second", xsg_q[1], 170);
      chk("f3_xsg_third", xsg_q[2], 339);
      chk("f3_xsg_clocks", n_xsg, 12);
      chk("f3_xv_rises", n_xv_rise, 21);
      chk("f3_xv_clocks", n_xv, 42);
      chk("f3_hread_clocks", n_hr, 420);
      chk("f3_lval_clocks", n_lval, 120);
      chk("f3_lval_bursts", n_burst, 12);
      chk("f3_fval_clocks", n_fval, 231);
      chk("f3_done_count", fd_q.size(), 3);
      chk("f3_done_first", fd_q[0], 168);
      chk("f3_done_last", fd_q[2], 506);
      chk("f3_pulse_widths", bad_w, 0);
      chk("f3_region_map", bad_map, 0);
      // enable dropped at vcnt 3 completes the frame and stops
      en = 1'b0;
      do_reset();
      reset_n = 1'b1; en = 1'b1;
      clr();
      watch(400, 1'b1);
      chk("drop_xsg_rises", xsg_q.size(), 1);
      chk("drop_xv_rises", n_xv_rise, 7);
      chk("drop_hread_clocks", n_hr, 140);
      chk("drop_done_count", fd_q.size(), 1);
      chk("drop_done_at", fd_q[0], 168);
      chk("drop_busy_end", o_busy, 0);
      chk("drop_region_map", bad_map, 0);
      // reset during the vcnt=2 XV pulse
      do_reset();
      reset_n = 1'b1; en = 1'b1;
      found = 0;
      for (int k = 0; k < 300 && found == 0; k++) begin
         @(negedge clk);
         if (o_xv && ov_vcnt == 2) found = 1;
      end
      chk("mid_reach_xv_v2", found, 1);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_outs", outs, 0);
      reset_n = 1'b1;
      clr();
      watch(30, 1'b0);
      chk("mid_xsg_first", xsg_q.size() > 0 ? xsg_q[0] : 0, 1);
      chk("mid_xsg_clocks", n_xsg, 4);
      chk("mid_region_map", bad_map + bad_w, 0);
      // second parameter set: two frames
      en = 1'b0;
      do_reset();
      reset_n = 1'b1; en2 = 1'b1;
      c2 = 0; x2 = 0; xr2 = 0; hr2 = 0; lv2 = 0; lb2 = 0; fd2 = 0; fd2_first = 0; pad2 = 0; fv2 = 0;
      pxv2 = 1'b0; plv2 = 1'b0;
      repeat (140) begin
         @(negedge clk);
         c2++;
         x2 += int'(b_xsg); hr2 += int'(b_hread); lv2 += int'(b_lval); fv2 += int'(b_fval);
         if (b_xv && !pxv2) xr2++;
         if (b_lval && !plv2) lb2++;
         if (b_frame_done) begin fd2++; if (fd2_first == 0) fd2_first = c2; end
         if (b_hread && b_hcnt == 8 && b_pix_type == 2'd3) pad2++;
         pxv2 = b_xv; plv2 = b_lval;
      end
      chk("p2_xsg_clocks", x2, 2);
      chk("p2_xv_rises", xr2, 12);
      chk("p2_hread_clocks", hr2, 108);
      chk("p2_lval_clocks", lv2, 30);
      chk("p2_lval_bursts", lb2, 6);
      chk("p2_fval_clocks", fv2, 52);
      chk("p2_done_count", fd2, 2);
      chk("p2_done_first", fd2_first, 69);
      chk("p2_pad_pixels", pad2, 12);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
